// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB3 slave with byte-writable memory.
// Holds the FSM state encoding, wait-counter width and error-response codes.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb_state_e;

  localparam logic SLVERR_OKAY  = 1'b0;
  localparam logic SLVERR_ERROR = 1'b1;

  // Wide enough for up to 15 inserted wait states.
  localparam int CNT_W = 4;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_wsmem_array.sv
// DEPTH x DATA_W storage with a byte-enable write port and a registered read port.
// A read that collides with a same-cycle write to the same word returns the new bytes.
module apb_wsmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 200,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the storage array carries no reset; clearing a RAM costs a full sweep and
  //       software never relies on power-up contents. Only the read register resets.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      if (rd_clr_i) begin
        rdata_q <= '0;
      end else begin
        for (int i = 0; i < STRB_W; i++) begin
          rdata_q[8*i +: 8] <= (we_i && (waddr_i == raddr_i) && wstrb_i[i])
                               ? wdata_i[8*i +: 8] : mem_q[raddr_i][8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_wsmem.sv
// APB3 slave in front of a byte-writable memory: wait-state FSM, request latch,
// range check and slave-error response. Storage lives in apb_wsmem_array.
module apb_slave_wsmem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 200,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int               STRB_W  = strb_w(DATA_W);
  localparam logic [31:0]      DEPTH_U = 32'(DEPTH);
  localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

  apb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              write_q, err_q, pready_q, pslverr_q;

  logic              setup, start, proto_err, addr_err, wait_last;
  logic              mem_we, rd_en, rd_clr;
  logic [ADDR_W-1:0] raddr;

  assign setup     = psel && !penable;
  assign start     = setup && (state_q != WAIT);
  assign proto_err = psel && penable && (state_q == IDLE);
  assign addr_err  = (32'(paddr) >= DEPTH_U);
  assign wait_last = (state_q == WAIT) && psel && penable && (cnt_q == CNT_W'(1));
  assign mem_we    = (state_q == DONE) && write_q && !err_q && !rst;

  // Read data is captured on the edge that enters DONE, from whichever source
  // (live bus or latched request) is current on that edge.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_en  = 1'b0;
    rd_clr = 1'b0;
    raddr  = addr_q;
    if (start && (WAIT_STATES == 0)) begin
      rd_en  = !pwrite;
      rd_clr = addr_err;
      raddr  = paddr;
    end else if (proto_err) begin
      rd_en  = !pwrite;
      rd_clr = 1'b1;
    end else if (wait_last) begin
      rd_en  = !write_q;
      rd_clr = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= SLVERR_OKAY;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= SLVERR_OKAY;
      if (start) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        err_q   <= addr_err;
        cnt_q   <= WS_INIT;
        if (WAIT_STATES == 0) begin
          state_q   <= DONE;
          pready_q  <= 1'b1;
          pslverr_q <= addr_err ? SLVERR_ERROR : SLVERR_OKAY;
        end else begin
          state_q <= WAIT;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (proto_err) begin
              state_q   <= DONE;
              write_q   <= pwrite;
              err_q     <= 1'b1;
              pready_q  <= 1'b1;
              pslverr_q <= SLVERR_ERROR;
            end
          end
          WAIT: begin
            if (!psel) begin
              state_q <= IDLE;
            end else if (penable) begin
              cnt_q <= cnt_q - CNT_W'(1);
              if (wait_last) begin
                state_q   <= DONE;
                pready_q  <= 1'b1;
                pslverr_q <= err_q ? SLVERR_ERROR : SLVERR_OKAY;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  apb_wsmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .STRB_W (STRB_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .we_i     (mem_we),
    .waddr_i  (addr_q),
    .wdata_i  (wdata_q),
    .wstrb_i  (strb_q),
    .rd_en_i  (rd_en),
    .rd_clr_i (rd_clr),
    .raddr_i  (raddr),
    .rdata_o  (prdata)
  );

  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
